s3g_tx: RTL and testbench
=========================

Name: s3g_tx

Overview:
- S3G packet transmitter; the host-bound counterpart of the S3G receiver.
- Frames a payload held in an internal 256x8 buffer as: 0xD5, length, payload[0..len-1], CRC-8.
- Feeds bytes one at a time to the UART transmitter through a tx_start/tx_busy handshake.
- Sits between the response-building logic, which fills the buffer and pulses send, and the UART TX.

Parameters:
- SYNC_BYTE, 8'hD5, start-of-packet byte.
- ADDR_W, 8, buffer address width; buffer depth is 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- buf_wr_en  in  1  buffer write strobe
- buf_wr_addr  in  8  buffer write address
- buf_wr_data  in  8  buffer write data
- payload_len  in  8  payload byte count; sampled on send
- send  in  1  start-transmission pulse
- tx_busy  in  1  UART busy; high while a byte is shifting
- tx_data  out  8  byte to UART; valid when tx_start=1
- tx_start  out  1  one-cycle byte-issue pulse
- busy  out  1  high from accepted send until packet_sent
- packet_sent  out  1  one-cycle pulse after the CRC byte is accepted

Behaviour:
- Reset: state=S_IDLE, tx_start=0, tx_data=0, busy=0, packet_sent=0, crc=0, byte_cnt=0, rd_addr=0. Buffer contents are not cleared.
- Buffer: synchronous write, 1-cycle registered read.
  - Writes with buf_wr_en=1 while busy=1 are ignored.
  - Writes while idle take effect on the next cycle.
- States: S_IDLE, S_SYNC, S_LEN, S_DATA, S_CRC, S_DONE.
- S_IDLE:
  - send=1 latches payload_len into byte_cnt, clears crc, sets rd_addr=0, sets busy=1, and moves to S_SYNC.
  - send while busy=1 is ignored; there is no queueing.
- Issue rule, all emitting states:
  - A byte is issued (tx_start=1 for exactly one cycle, with tx_data valid) only when tx_busy=0 and no tx_start occurred in the previous cycle. This covers the UART's 1-cycle busy-assert latency.
  - tx_data holds its value until the next issue.
- S_SYNC: issue SYNC_BYTE, then go to S_LEN.
- S_LEN: issue byte_cnt. Go to S_DATA if byte_cnt!=0, else S_CRC.
- S_DATA:
  - Issue buffer[rd_addr].
  - crc <= nextCRC8_D8(byte, crc).
  - rd_addr+1, byte_cnt-1.
  - When byte_cnt==1 at issue, go to S_CRC.
  - Read data is prefetched so the 1-cycle RAM latency never delays an issue that would otherwise be allowed.
- CRC rules:
  - CRC covers payload bytes only, never sync or length.
  - Initial value 0.
  - Uses the shared CRC-8 function (nextCRC8_D8 from crc8.v), identical to the receiver.
- S_CRC: issue crc, go to S_DONE.
- S_DONE:
  - Wait for tx_busy=0 on a cycle not immediately after tx_start, i.e. the last byte has fully left the UART.
  - Then pulse packet_sent=1, set busy=0 and return to S_IDLE in the same cycle.
  - A send in the cycle after packet_sent is accepted.
- Lengths:
  - payload_len=0 produces D5 00 00.
  - payload_len=255 reads addresses 0..254.
  - rd_addr wraps mod 256 and is never observed past 255.
- Illegal state encodings go to S_IDLE with busy=0 and no tx_start.
- rst asserted mid-packet:
  - Next cycle is the reset state; any pending issue is dropped.
  - The UART may still finish its current byte, but no further tx_start is produced.

Optional Feature:
- Macro: S3G_TX_CRC_CORRUPT_EN.
- Defined:
  - Adds input port crc_corrupt (1 bit), sampled with send.
  - If it was 1, the transmitted CRC byte is crc^8'h01, to exercise receiver packet_error paths.
- Undefined:
  - The port does not exist and the CRC is always correct.
  - Logic is otherwise identical.

Decomposition:
- Shared package/include:
  - state localparams S_IDLE..S_DONE;
  - SYNC_BYTE value 8'hD5;
  - crc8.v function nextCRC8_D8, shared with the receiver.
- One natural sub-module: s3g_tx_buf, a 256x8 simple dual-port RAM with a registered read port.

Test Plan:
- Payload len=1, buffer[0]=8'h01, tx_busy modelled as 10 cycles per byte -> tx_start bytes D5,01,01,5E; one packet_sent pulse; busy low afterwards.
- len=0 -> D5,00,00; packet_sent pulses once.
- len=16, buffer=00..0F, UART stall holding tx_busy high 40 extra cycles mid-payload -> 19 bytes in order; no tx_start while tx_busy=1; CRC equals the software model; loopback into s3g_rx gives packet_done and buf0..buf15 = 00..0F.
- send pulsed while busy, plus buf_wr_en to addr 0 while busy -> no second packet and buffer[0] unchanged; a send in the cycle after packet_sent starts a new packet.
- rst asserted after the 3rd byte of a len=8 packet -> no further tx_start, all outputs at reset values next cycle; a new send then transmits a full packet from D5.
- With S3G_TX_CRC_CORRUPT_EN, crc_corrupt=1, len=1, byte 01 -> final byte 5F; s3g_rx loopback raises packet_error.

Source files
------------

// File: rtl/s3g_tx_pkg.sv
// Shared definitions for the S3G transmitter: FSM state encoding, default
// sync byte and the CRC-8 update function also used by the S3G receiver.
package s3g_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hD5;

  // CRC-8, reflected polynomial 0x8C (Dallas/Maxim), data shifted LSB first.
  // Must stay bit-identical to the receiver's copy.
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data,
                                             input logic [7:0] crc);
    logic [7:0] c;
    logic [7:0] d;
    logic       mix;
    c = crc;
    d = data;
    for (int i = 0; i < 8; i++) begin
      mix = c[0] ^ d[0];
      c   = {1'b0, c[7:1]};
      if (mix) c = c ^ 8'h8C;
      d   = {1'b0, d[7:1]};
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_tx_buf.sv
// Payload buffer for the S3G transmitter: simple dual-port RAM, synchronous
// write, registered read (data appears one cycle after the address).
module s3g_tx_buf
  import s3g_tx_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/s3g_tx.sv
// S3G packet transmitter: frames buffer contents as SYNC, length, payload,
// CRC-8 and hands bytes to the UART one at a time via tx_start/tx_busy.
// Optional build macro S3G_TX_CRC_CORRUPT_EN adds input crc_corrupt, which
// (when sampled high with send) flips bit 0 of the transmitted CRC byte.
//
// state  | meaning
// S_IDLE | waiting for send; buffer writable
// S_SYNC | issue the sync byte
// S_LEN  | issue the payload length
// S_DATA | issue payload bytes, accumulate CRC
// S_CRC  | issue the CRC byte
// S_DONE | wait for the UART to drain, then pulse packet_sent
module s3g_tx
  import s3g_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_wr_en,
  input  logic [ADDR_W-1:0] buf_wr_addr,
  input  logic [7:0]        buf_wr_data,
  input  logic [7:0]        payload_len,
  input  logic              send,
`ifdef S3G_TX_CRC_CORRUPT_EN
  input  logic              crc_corrupt,
`endif
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              packet_sent
);

  state_t            state, state_n;
  logic [7:0]        byte_cnt, byte_cnt_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [7:0]        crc, crc_n;
  logic [7:0]        tx_data_n;
  logic              tx_start_n, busy_n, sent_n;
  logic              tx_start_d;
  logic              corrupt_q, corrupt_n;
  logic              corrupt_in;
  logic [7:0]        rd_data;
  logic              can_issue;

`ifdef S3G_TX_CRC_CORRUPT_EN
  assign corrupt_in = crc_corrupt;
`else
  assign corrupt_in = 1'b0;
`endif

  // The buffer is frozen while a packet is in flight.
  s3g_tx_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en & ~busy),
    .wr_addr (buf_wr_addr),
    .wr_data (buf_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // tx_start is registered, so blocking on both the live pulse and its delayed
  // copy keeps two idle cycles after every issue: enough for the UART to raise
  // tx_busy and for the prefetched read of the next payload byte to land.
  assign can_issue = ~tx_busy & ~tx_start & ~tx_start_d;

  // Next-state and output decode.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    rd_addr_n  = rd_addr;
    crc_n      = crc;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    busy_n     = busy;
    sent_n     = 1'b0;
    corrupt_n  = corrupt_q;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (send) begin
          byte_cnt_n = payload_len;
          crc_n      = 8'h00;
          rd_addr_n  = '0;
          busy_n     = 1'b1;
          corrupt_n  = corrupt_in;
          state_n    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (can_issue) begin
          tx_start_n = 1'b1;
          tx_data_n  = SYNC_BYTE;
          state_n    = S_LEN;
        end
      end
      S_LEN: begin
        if (can_issue) begin
          tx_start_n = 1'b1;
          tx_data_n  = byte_cnt;
          state_n    = (byte_cnt != 8'd0) ? S_DATA : S_CRC;
        end
      end
      S_DATA: begin
        if (can_issue) begin
          tx_start_n = 1'b1;
          tx_data_n  = rd_data;
          crc_n      = nextCRC8_D8(rd_data, crc);
          rd_addr_n  = rd_addr + 1'b1;
          byte_cnt_n = byte_cnt - 8'd1;
          if (byte_cnt == 8'd1) state_n = S_CRC;
        end
      end
      S_CRC: begin
        if (can_issue) begin
          tx_start_n = 1'b1;
          tx_data_n  = crc ^ {7'b0, corrupt_q};
          state_n    = S_DONE;
        end
      end
      S_DONE: begin
        if (can_issue) begin
          sent_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_cnt    <= 8'd0;
      rd_addr     <= '0;
      crc         <= 8'd0;
      tx_data     <= 8'd0;
      tx_start    <= 1'b0;
      tx_start_d  <= 1'b0;
      busy        <= 1'b0;
      packet_sent <= 1'b0;
      corrupt_q   <= 1'b0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      rd_addr     <= rd_addr_n;
      crc         <= crc_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      tx_start_d  <= tx_start;
      busy        <= busy_n;
      packet_sent <= sent_n;
      corrupt_q   <= corrupt_n;
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Directed + randomized bench for s3g_tx with a simple UART busy model and a
// packet-level reference model (byte list + CRC-8/MAXIM by polynomial division).
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       buf_wr_en = 1'b0;
  logic [7:0] buf_wr_addr = 8'h00;
  logic [7:0] buf_wr_data = 8'h00;
  logic [7:0] payload_len = 8'h00;
  logic       send = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, busy, packet_sent;
`ifdef S3G_TX_CRC_CORRUPT_EN
  logic       crc_corrupt = 1'b0;
`endif

  s3g_tx dut (
    .clk         (clk),
    .rst         (rst),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .payload_len (payload_len),
    .send        (send),
`ifdef S3G_TX_CRC_CORRUPT_EN
    .crc_corrupt (crc_corrupt),
`endif
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .packet_sent (packet_sent)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]   mem [256];
  byte unsigned cap[$];
  int           ps_cnt = 0;
  int           viol = 0;
  logic         prev_start = 1'b0;
  int           uart_cycles = 10;
  int           stall_idx = -1;

  // UART model: busy rises one cycle after it samples tx_start, stays up
  // uart_cycles cycles (plus 40 for the stalled byte). Not affected by rst.
  logic pend = 1'b0;
  int   ucnt = 0;
  always @(posedge clk) begin
    if (pend) begin
      tx_busy <= 1'b1;
      ucnt    <= uart_cycles + ((cap.size() - 1 == stall_idx) ? 40 : 0);
      pend    <= 1'b0;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else if (ucnt == 1) begin
      ucnt    <= 0;
      tx_busy <= 1'b0;
    end
    if (tx_start) pend <= 1'b1;
  end

  // Byte capture and handshake-rule monitor.
  always @(negedge clk) begin
    if (tx_start) begin
      cap.push_back(tx_data);
      if (tx_busy) viol++;
      if (prev_start) viol++;
    end
    prev_start = tx_start;
    if (packet_sent) ps_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // CRC-8/MAXIM as MSB-first division by x^8+x^5+x^4+1 on bit-reversed bytes.
  function automatic logic [7:0] crc_model(input int len);
    logic [7:0] c;
    logic [7:0] r;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < len; k++) begin
      r = rev8(mem[k]);
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ r[i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h31;
      end
    end
    return rev8(c);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    buf_wr_en = 1'b1; buf_wr_addr = a; buf_wr_data = d;
    mem[a] = d;
    tick();
    buf_wr_en = 1'b0;
  endtask

  task automatic do_send(input int len);
    payload_len = len[7:0];
    send = 1'b1;
    tick();
    send = 1'b0;
    chk("busy_after_send", busy, 1);
  endtask

  task automatic wait_sent();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30000; i++) begin
      if (packet_sent) begin ok = 1; break; end
      tick();
    end
    chk("packet_sent_seen", ok, 1);
    chk("busy_low_at_sent", busy, 0);
  endtask

  task automatic check_pkt(input string tag, input int start, input int len);
    byte unsigned exp[$];
    exp.push_back(8'hD5);
    exp.push_back(len[7:0]);
    for (int k = 0; k < len; k++) exp.push_back(mem[k]);
    exp.push_back(crc_model(len));
    chk({tag, "_nbytes"}, cap.size() - start, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (start + i < cap.size())
        chk($sformatf("%s_b%0d", tag, i), cap[start+i], exp[i]);
  endtask

  task automatic run(input string tag, input int len);
    int start, ps0;
    start = cap.size();
    ps0   = ps_cnt;
    do_send(len);
    wait_sent();
    check_pkt(tag, start, len);
    repeat (3) tick();
    chk({tag, "_one_sent_pulse"}, ps_cnt - ps0, 1);
  endtask

  initial begin
    int start, start2, ps0, n, len;
    bit ok;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_packet_sent", packet_sent, 0);

    // len=1, byte 01 -> D5 01 01 5E
    uart_cycles = 10;
    wr(8'd0, 8'h01);
    start = cap.size();
    run("len1", 1);
    if (cap.size() > start + 3) chk("len1_crc_const", cap[start+3], 8'h5E);

    // len=0 -> D5 00 00
    run("len0", 0);

    // len=16, 00..0F, 40-cycle stall mid-payload
    for (int i = 0; i < 16; i++) wr(i[7:0], i[7:0]);
    stall_idx = cap.size() + 8;
    run("len16_stall", 16);
    stall_idx = -1;

    // send + buffer write while busy are ignored; send right after packet_sent accepted
    uart_cycles = 4;
    for (int i = 0; i < 4; i++) wr(i[7:0], 8'($urandom));
    start = cap.size();
    ps0   = ps_cnt;
    do_send(4);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cap.size() - start >= 2) begin ok = 1; break; end
      tick();
    end
    chk("busy_test_progress", ok, 1);
    send = 1'b1; payload_len = 8'd9;
    buf_wr_en = 1'b1; buf_wr_addr = 8'd0; buf_wr_data = ~mem[0];
    tick();
    send = 1'b0; buf_wr_en = 1'b0;
    wait_sent();
    check_pkt("send_while_busy", start, 4);
    tick();
    start2 = cap.size();
    do_send(1);
    wait_sent();
    check_pkt("back_to_back", start2, 1);
    chk("busy_test_pulses", ps_cnt - ps0, 2);

    // reset after 3rd byte of a len=8 packet
    uart_cycles = 6;
    for (int i = 0; i < 8; i++) wr(i[7:0], 8'($urandom));
    start = cap.size();
    ps0   = ps_cnt;
    do_send(8);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cap.size() - start >= 3) begin ok = 1; break; end
      tick();
    end
    chk("rst_test_progress", ok, 1);
    rst = 1'b1;
    tick();
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_packet_sent", packet_sent, 0);
    rst = 1'b0;
    n = cap.size();
    repeat (60) tick();
    chk("midrst_no_more_bytes", cap.size(), n);
    chk("midrst_no_sent", ps_cnt, ps0);
    run("after_rst", 8);

    // randomized packets, including the 255-byte maximum
    for (int k = 0; k < 5; k++) begin
      len = (k == 0) ? 255 : int'($urandom_range(1, 40));
      uart_cycles = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) wr(i[7:0], 8'($urandom));
      run($sformatf("rand%0d", k), len);
    end

    chk("handshake_rule", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
